clk_freq_monitor: RTL and testbench



---
 rtl/clk_mon_pkg.sv | 18 +
 rtl/clk_mon_edge_sync.sv | 23 ++
 rtl/clk_freq_monitor.sv | 129 ++++++++++++
 tb/tb_clk_freq_monitor.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/clk_mon_pkg.sv
// Shared types and default parameters for the clock frequency monitor.
// Optional min/max tracking is enabled with CLK_MON_MINMAX_EN.
`timescale 1ns/1ps
package clk_mon_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ARM,
    COUNT,
    REPORT
  } state_e;

  localparam int DEF_GATE_CYCLES    = 1000;
  localparam int DEF_COUNT_W        = 16;
  localparam int DEF_TIMEOUT_CYCLES = 64;
  localparam int DEF_MIN_EDGES      = 4;

endpackage

// File: rtl/clk_mon_edge_sync.sv
// Three-flop synchronizer for an asynchronous level with a rising-edge
// pulse; at most one pulse per clk cycle.
`timescale 1ns/1ps
module clk_mon_edge_sync (
  input  logic clk,
  input  logic reset,
  input  logic sig,
  output logic rise
);

  logic [2:0] sync_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[1:0], sig};
    end
  end

  assign rise = sync_q[1] & ~sync_q[2];

endmodule

// File: rtl/clk_freq_monitor.sv
// Gated edge counter measuring an async clock in the usb_clk domain.
// Define CLK_MON_MINMAX_EN to add min/max window tracking.
`timescale 1ns/1ps
module clk_freq_monitor
  import clk_mon_pkg::*;
#(
  parameter int GATE_CYCLES    = DEF_GATE_CYCLES,
  parameter int COUNT_W        = DEF_COUNT_W,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int MIN_EDGES      = DEF_MIN_EDGES
) (
  input  logic               usb_clk,
  input  logic               reset,
  input  logic               I_enable,
  input  logic               I_clk_mon,
`ifdef CLK_MON_MINMAX_EN
  input  logic               I_minmax_clr,
  output logic [COUNT_W-1:0] O_freq_min,
  output logic [COUNT_W-1:0] O_freq_max,
`endif
  output logic [COUNT_W-1:0] O_freq_count,
  output logic               O_freq_valid,
  output logic               O_clk_present,
  output logic               O_saturated
);

  localparam int GW = $clog2(GATE_CYCLES);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [GW-1:0]      GATE_LAST = GW'(GATE_CYCLES - 1);
  localparam logic [TW-1:0]      TO_HIT    = TW'(TIMEOUT_CYCLES);
  localparam logic [COUNT_W-1:0] CNT_MAX   = '1;
  localparam logic [COUNT_W-1:0] CNT_MIN   = COUNT_W'(MIN_EDGES);

  state_e state, state_n;

  logic [GW-1:0]      gate_cnt;
  logic [COUNT_W-1:0] edge_cnt;
  logic [TW-1:0]      to_cnt;
  logic               rise;
  logic               to_hit;

  clk_mon_edge_sync u_sync (
    .clk   (usb_clk),
    .reset (reset),
    .sig   (I_clk_mon),
    .rise  (rise)
  );

  always_ff @(posedge usb_clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (I_enable) state_n = ARM;
      ARM:     state_n = I_enable ? COUNT : IDLE;
      COUNT: begin
        if (!I_enable) begin
          state_n = IDLE;
        end else if (gate_cnt == GATE_LAST) begin
          state_n = REPORT;
        end
      end
      REPORT:  state_n = I_enable ? ARM : IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Counters only advance in COUNT; every other state clears them,
  // while REPORT still sees the final edge count for this cycle.
  always_ff @(posedge usb_clk) begin
    if (reset || state != COUNT) begin
      gate_cnt <= '0;
      edge_cnt <= '0;
    end else begin
      gate_cnt <= gate_cnt + 1'b1;
      if (rise && edge_cnt != CNT_MAX) begin
        edge_cnt <= edge_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge usb_clk) begin
    if (reset || state == IDLE || rise) begin
      to_cnt <= '0;
    end else if (to_cnt != TO_HIT) begin
      to_cnt <= to_cnt + 1'b1;
    end
  end

  assign to_hit = (to_cnt == TO_HIT);

  always_ff @(posedge usb_clk) begin
    if (reset) begin
      O_freq_count  <= '0;
      O_freq_valid  <= 1'b0;
      O_clk_present <= 1'b0;
      O_saturated   <= 1'b0;
    end else begin
      O_freq_valid <= (state == REPORT);
      if (state == REPORT) begin
        O_freq_count  <= edge_cnt;
        O_saturated   <= (edge_cnt == CNT_MAX);
        O_clk_present <= (edge_cnt >= CNT_MIN);
      end else if (to_hit) begin
        O_clk_present <= 1'b0;
      end
    end
  end

`ifdef CLK_MON_MINMAX_EN
  always_ff @(posedge usb_clk) begin
    if (reset || I_minmax_clr) begin
      O_freq_min <= CNT_MAX;
      O_freq_max <= '0;
    end else if (state == REPORT) begin
      if (edge_cnt < O_freq_min) O_freq_min <= edge_cnt;
      if (edge_cnt > O_freq_max) O_freq_max <= edge_cnt;
    end
  end
`endif

endmodule

// File: tb/tb_clk_freq_monitor.sv
// Directed/randomized bench for clk_freq_monitor; model predicts counts
// from monitored period and gate time.
`timescale 1ns/1ps
module tb_clk_freq_monitor;

  localparam int GATE = 1000;
  localparam int CW   = 16;
  localparam int TO   = 64;
  localparam int MINE = 4;
  localparam real TCLK = 10.0;

  logic usb_clk = 1'b0;
  logic reset;
  logic I_enable;
  logic I_clk_mon;

  logic [CW-1:0] cnt;
  logic          vld, pres, sat;
  logic [3:0]    cnt_b;
  logic          vld_b, pres_b, sat_b;
`ifdef CLK_MON_MINMAX_EN
  logic          clr;
  logic [CW-1:0] fmin, fmax;
  logic [3:0]    fmin_b, fmax_b;
`endif

  int  errors = 0;
  int  checks = 0;
  real mon_half = 20.0;
  bit  mon_run = 1'b1;
  real last_rise = 0.0;

  always #5 usb_clk = ~usb_clk;

  initial begin
    I_clk_mon = 1'b0;
    #3.3;
    forever begin
      if (mon_run) begin
        #(mon_half);
        if (mon_run) begin
          I_clk_mon = ~I_clk_mon;
          if (I_clk_mon) last_rise = $realtime;
        end else begin
          I_clk_mon = 1'b0;
        end
      end else begin
        #1;
      end
    end
  end

  clk_freq_monitor #(
    .GATE_CYCLES(GATE), .COUNT_W(CW),
    .TIMEOUT_CYCLES(TO), .MIN_EDGES(MINE)
  ) dut (
    .usb_clk       (usb_clk),
    .reset         (reset),
    .I_enable      (I_enable),
    .I_clk_mon     (I_clk_mon),
`ifdef CLK_MON_MINMAX_EN
    .I_minmax_clr  (clr),
    .O_freq_min    (fmin),
    .O_freq_max    (fmax),
`endif
    .O_freq_count  (cnt),
    .O_freq_valid  (vld),
    .O_clk_present (pres),
    .O_saturated   (sat)
  );

  clk_freq_monitor #(
    .GATE_CYCLES(100), .COUNT_W(4),
    .TIMEOUT_CYCLES(TO), .MIN_EDGES(MINE)
  ) dut_b (
    .usb_clk       (usb_clk),
    .reset         (reset),
    .I_enable      (I_enable),
    .I_clk_mon     (I_clk_mon),
`ifdef CLK_MON_MINMAX_EN
    .I_minmax_clr  (clr),
    .O_freq_min    (fmin_b),
    .O_freq_max    (fmax_b),
`endif
    .O_freq_count  (cnt_b),
    .O_freq_valid  (vld_b),
    .O_clk_present (pres_b),
    .O_saturated   (sat_b)
  );

  task automatic step(input int n);
    repeat (n) @(posedge usb_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s: got %0d want %0d", tag, got, want);
    end
  endtask

  task automatic chk_rng(input string tag, input longint got,
                         input longint lo, input longint hi);
    checks++;
    assert ((got >= lo && got <= hi) === 1'b1) else begin
      errors++;
      $error("FAIL %s: got %0d want %0d..%0d", tag, got, lo, hi);
    end
  endtask

  task automatic wait_valid(input int limit, output int cyc);
    cyc = 0;
    while (cyc < limit) begin
      step(1);
      cyc++;
      if (vld === 1'b1) return;
    end
    checks++;
    errors++;
    $error("FAIL valid_timeout: got none want pulse in %0d", limit);
  endtask

  // Expected edges in one gate window for a given half period (ns).
  function automatic real model_count(input real half);
    return (GATE * TCLK) / (2.0 * half);
  endfunction

  initial begin
    int  cyc;
    int  elapsed;
    int  seen;
    real half;
    real expc;
    logic [CW-1:0] held_cnt;
    logic          held_pres;

    reset    = 1'b1;
    I_enable = 1'b0;
`ifdef CLK_MON_MINMAX_EN
    clr      = 1'b0;
`endif
    step(5);
    chk("rst_count", cnt, 0);
    chk("rst_valid", vld, 0);
    chk("rst_present", pres, 0);
    chk("rst_sat", sat, 0);
    reset = 1'b0;
    step(3);
    chk("idle_no_valid", vld, 0);

    I_enable = 1'b1;
    wait_valid(1100, cyc);
    chk_rng("first_latency", cyc, 999, 1005);
    chk_rng("count_25m", cnt, 249, 251);
    chk("present_25m", pres, 1);
    chk("sat_25m", sat, 0);
    step(1);
    chk("valid_one_cycle", vld, 0);
    chk("b_count_sat", cnt_b, 15);
    chk("b_saturated", sat_b, 1);
    chk("b_present", pres_b, 1);

    for (int i = 0; i < 4; i++) begin
      half = $urandom_range(150, 1000) / 10.0;
      mon_half = half;
      expc = model_count(half);
      wait_valid(1100, cyc);
      wait_valid(1100, cyc);
      chk_rng("rand_period", cyc, 1002, 1002);
      chk_rng("rand_count", cnt, longint'(expc - 1.5 + 0.999),
              longint'(expc + 1.5 - 0.5));
      chk("rand_present", pres, 1);
    end

    mon_half = 20.0;
    wait_valid(1100, cyc);
    wait_valid(1100, cyc);
    step(300);
    mon_run = 1'b0;
    elapsed = 0;
    while (pres === 1'b1 && elapsed < TO + 40) begin
      step(1);
      elapsed++;
    end
    elapsed = $rtoi(($realtime - last_rise) / TCLK);
    chk_rng("timeout_latency", elapsed, 0, TO + 4);
    wait_valid(1100, cyc);
    wait_valid(1100, cyc);
    chk("stopped_count", cnt, 0);
    chk("stopped_present", pres, 0);

    mon_run = 1'b1;
    wait_valid(1100, cyc);
    wait_valid(1100, cyc);
    chk_rng("restart_count", cnt, 249, 251);
    held_cnt  = cnt;
    held_pres = pres;
    step(500);
    I_enable = 1'b0;
    seen = 0;
    for (int i = 0; i < 1100; i++) begin
      step(1);
      if (vld === 1'b1) seen++;
    end
    chk("dis_no_valid", seen, 0);
    chk("dis_count_held", cnt, held_cnt);
    chk("dis_present_held", pres, held_pres);

    I_enable = 1'b1;
    wait_valid(1100, cyc);
    step(300);
    reset = 1'b1;
    step(1);
    chk("mid_rst_count", cnt, 0);
    chk("mid_rst_valid", vld, 0);
    chk("mid_rst_present", pres, 0);
    chk("mid_rst_sat", sat, 0);
    chk("mid_rst_b_count", cnt_b, 0);
    reset = 1'b0;
    wait_valid(1100, cyc);
    chk_rng("rearm_latency", cyc, 999, 1005);
    chk_rng("rearm_count", cnt, 249, 251);
    chk("rearm_present", pres, 1);

`ifdef CLK_MON_MINMAX_EN
    mon_half = 50.0;
    wait_valid(1100, cyc);
    clr = 1'b1;
    step(1);
    clr = 1'b0;
    chk("clr_min", fmin, 16'hFFFF);
    chk("clr_max", fmax, 0);
    wait_valid(1100, cyc);
    chk_rng("count_10m", cnt, 99, 101);
    mon_half = 20.0;
    wait_valid(1100, cyc);
    wait_valid(1100, cyc);
    mon_half = 50.0;
    wait_valid(1100, cyc);
    wait_valid(1100, cyc);
    chk_rng("mm_min", fmin, 99, 101);
    chk_rng("mm_max", fmax, 249, 251);
    clr = 1'b1;
    step(1);
    clr = 1'b0;
    chk("clr2_min", fmin, 16'hFFFF);
    chk("clr2_max", fmax, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: got no finish want finish before 2ms");
    $fatal(1, "watchdog expired");
  end

endmodule
